// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between fetch and the MEM stage,
// data first with a starvation guard, sequencing fixed-latency accesses.
module mem_port_arbiter #(
    parameter int LATENCY      = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req,
    input  logic [0:31] if_addr,
    output logic [0:31] if_rdata,
    output logic        if_ready,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [0:31] dm_addr,
    input  logic [0:31] dm_wdata,
    input  logic [0:3]  dm_be,
    output logic [0:31] dm_rdata,
    output logic        dm_ready,
    output logic        stall_fetch,
    output logic        stall_mem,
    output logic        mem_en,
    output logic        mem_we,
    output logic [0:31] mem_addr,
    output logic [0:31] mem_wdata,
    output logic [0:3]  mem_be,
    input  logic [0:31] mem_rdata
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    localparam logic [3:0] LAT = 4'(LATENCY);
    localparam logic [3:0] LIM = 4'(STARVE_LIMIT);
    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        we_q, we_d;
    logic [3:0]  cnt_q, cnt_d, starve_q, starve_d;
    logic [0:31] addr_q, addr_d, wdata_q, wdata_d;
    logic [0:31] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
    logic [0:3]  be_q, be_d;
    logic        data_wins;
    // fetch only overtakes data once it has watched LIM data grants in a row
    assign data_wins = dm_req & ~(if_req & (starve_q == LIM));
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        cnt_d      = cnt_q;
        starve_d   = starve_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        unique case (state_q)
            IDLE: begin
                if (data_wins) begin
                    state_d  = ACCESS;
                    owner_d  = 1'b1;
                    addr_d   = dm_addr;
                    wdata_d  = dm_wdata;
                    be_d     = dm_be;
                    we_d     = dm_we;
                    cnt_d    = LAT;
                    starve_d = if_req ? ((starve_q < LIM) ? starve_q + 4'd1 : LIM) : 4'd0;
                end else if (if_req) begin
                    state_d  = ACCESS;
                    owner_d  = 1'b0;
                    addr_d   = if_addr;
                    be_d     = 4'b1111;
                    we_d     = 1'b0;
                    cnt_d    = LAT;
                    starve_d = 4'd0;
                end
            end
            ACCESS: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                    if (owner_q) dm_rdata_d = mem_rdata;
                    else         if_rdata_d = mem_rdata;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            cnt_q      <= 4'd0;
            starve_q   <= 4'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            cnt_q      <= cnt_d;
            starve_q   <= starve_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end
    assign mem_en      = (state_q == ACCESS);
    assign mem_we      = mem_en & we_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign mem_be      = be_q;
    assign if_ready    = (state_q == RESP) & ~owner_q;
    assign dm_ready    = (state_q == RESP) & owner_q;
    assign if_rdata    = if_rdata_q;
    assign dm_rdata    = dm_rdata_q;
    assign stall_fetch = if_req & ~if_ready;
    assign stall_mem   = dm_req & ~dm_ready;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table plus corner-case sequences, checked by a
// scoreboard of expected accesses popped on each ready pulse.
module tb_mem_port_arbiter;
    localparam int L = 2;
    localparam int S = 4;
    logic        clock = 1'b0, reset = 1'b0;
    logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
    logic [0:31] if_addr = '0, dm_addr = '0, dm_wdata = '0, mem_rdata = '0;
    logic [0:3]  dm_be = '0;
    logic [0:31] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic        if_ready, dm_ready, stall_fetch, stall_mem, mem_en, mem_we;
    logic [0:3]  mem_be;

    mem_port_arbiter #(.LATENCY(L), .STARVE_LIMIT(S)) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_be(dm_be), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .stall_fetch(stall_fetch), .stall_mem(stall_mem),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        d;
        logic        we;
        logic [0:31] addr;
        logic [0:31] wdata;
        logic [0:31] rdata;
        logic [0:3]  be;
        int          exp_cyc;
    } txn_t;

    typedef struct {
        logic        d;
        logic        we;
        logic [0:31] addr;
        logic [0:31] wdata;
        logic [0:31] rdata;
        logic [0:3]  be;
    } vec_t;

    txn_t sb[$];
    txn_t t;
    vec_t vecs[6];
    int   errors = 0, checks = 0, cyc = 0, en_idx = 0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", n, cyc, act, exp);
        end
    endtask

    function automatic txn_t mk(input logic d, input logic we, input logic [0:31] a,
                                input logic [0:31] wd, input logic [0:31] rd,
                                input logic [0:3] be, input int e);
        txn_t x;
        x.d = d; x.we = we; x.addr = a; x.wdata = wd; x.rdata = rd; x.be = be; x.exp_cyc = e;
        return x;
    endfunction

    task automatic run_d(input logic we, input logic [0:31] a, input logic [0:31] wd,
                         input logic [0:3] be);
        logic got = 1'b0;
        dm_req = 1'b1; dm_we = we; dm_addr = a; dm_wdata = wd; dm_be = be;
        for (int i = 0; i < 80 && !got; i++) begin
            @(negedge clock);
            got = dm_ready;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL dm_timeout: no dm_ready for addr %h", a);
        end
        @(posedge clock); #1;
        dm_req = 1'b0;
    endtask

    task automatic run_i(input logic [0:31] a);
        logic got = 1'b0;
        if_req = 1'b1; if_addr = a;
        for (int i = 0; i < 80 && !got; i++) begin
            @(negedge clock);
            got = if_ready;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL if_timeout: no if_ready for addr %h", a);
        end
        @(posedge clock); #1;
        if_req = 1'b0;
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // monitor plus memory model: returns the front access's data only in its L-th mem_en cycle
    always @(negedge clock) begin
        if (!reset) begin
            chk("stall_fetch", stall_fetch, if_req & ~if_ready);
            chk("stall_mem", stall_mem, dm_req & ~dm_ready);
            chk("ready_exclusive", if_ready & dm_ready, 0);
            if (mem_en) begin
                chk("en_has_txn", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    chk("mem_addr", mem_addr, sb[0].addr);
                    chk("mem_we", mem_we, sb[0].we);
                    chk("mem_be", mem_be, sb[0].be);
                    if (sb[0].d) chk("mem_wdata", mem_wdata, sb[0].wdata);
                    chk("en_window", (cyc >= sb[0].exp_cyc - L) && (cyc < sb[0].exp_cyc), 1);
                end
            end
            if (if_ready | dm_ready) begin
                chk("ready_has_txn", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    t = sb.pop_front();
                    chk("ready_owner_d", dm_ready, t.d);
                    chk("ready_cycle", cyc, t.exp_cyc);
                    if (!t.we) chk("rdata", t.d ? dm_rdata : if_rdata, t.rdata);
                end
            end
        end
        en_idx = mem_en ? en_idx + 1 : 0;
        mem_rdata = (mem_en && en_idx == L && sb.size() != 0) ? sb[0].rdata : $urandom;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        logic seen;
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,          32'h4400_0300, 4'b1111};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_2000, 32'h0000_002A, 32'h0,          4'b1111};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_1004, 32'h0,          32'hA5A5_0001, 4'b1111};
        vecs[3] = '{1'b1, 1'b1, 32'h0000_3008, 32'h1234_5678, 32'h0,          4'b0101};
        vecs[4] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,          32'hFFFF_FFFF, 4'b1111};
        vecs[5] = '{1'b1, 1'b0, 32'h0000_0400, 32'h0,          32'h0BAD_F00D, 4'b0010};

        #2 reset = 1'b1;
        #1;
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_be", mem_be, 0);
        chk("rst_if_ready", if_ready, 0);
        chk("rst_dm_ready", dm_ready, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_dm_rdata", dm_rdata, 0);
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            c0 = cyc;
            sb.push_back(mk(vecs[i].d, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                            vecs[i].rdata, vecs[i].d ? vecs[i].be : 4'b1111, c0 + L + 1));
            if (vecs[i].d) run_d(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be);
            else           run_i(vecs[i].addr);
        end
        chk("if_rdata_hold", if_rdata, vecs[4].rdata);

        c0 = cyc;
        sb.push_back(mk(1'b1, 1'b0, 32'h0000_5000, 32'h0, 32'h1111_2222, 4'b1111, c0 + 3));
        sb.push_back(mk(1'b0, 1'b0, 32'h0000_0020, 32'h0, 32'h3333_4444, 4'b1111, c0 + 7));
        fork
            run_d(1'b0, 32'h0000_5000, 32'h0, 4'b1111);
            run_i(32'h0000_0020);
        join

        c0 = cyc;
        for (int k = 0; k < 4; k++)
            sb.push_back(mk(1'b1, 1'b0, 32'h0000_6000 + 32'(4 * k), 32'h0,
                            32'hD000_0000 + 32'(k), 4'b1111, c0 + 3 + 4 * k));
        sb.push_back(mk(1'b0, 1'b0, 32'h0000_0040, 32'h0, 32'hC0DE_0040, 4'b1111, c0 + 19));
        sb.push_back(mk(1'b1, 1'b0, 32'h0000_6010, 32'h0, 32'hD000_0004, 4'b1111, c0 + 23));
        fork
            for (int k = 0; k < 5; k++) run_d(1'b0, 32'h0000_6000 + 32'(4 * k), 32'h0, 4'b1111);
            run_i(32'h0000_0040);
        join

        c0 = cyc;
        sb.push_back(mk(1'b1, 1'b0, 32'h0000_7000, 32'h0, 32'hEEEE_EEEE, 4'b1111, c0 + 3));
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_7000; dm_be = 4'b1111;
        @(posedge clock); #1;
        @(posedge clock); #3;
        reset = 1'b1;
        #1;
        chk("abort_mem_en", mem_en, 0);
        chk("abort_dm_ready", dm_ready, 0);
        chk("abort_if_rdata", if_rdata, 0);
        chk("abort_mem_addr", mem_addr, 0);
        sb.delete();
        dm_req = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            seen = seen | dm_ready;
        end
        chk("abort_no_ready", seen, 0);
        @(posedge clock); #1;
        c0 = cyc;
        sb.push_back(mk(1'b0, 1'b0, 32'h0000_0000, 32'h0, 32'h5A5A_0000, 4'b1111, c0 + L + 1));
        run_i(32'h0000_0000);
        chk("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
